// File: rtl/rr_arbiter8_if.sv
// ---------------------------------------------------------------------------
// rr_arbiter8_if
// Bundle of the arbitration signals shared by the requesters and the
// round-robin arbiter. Clock and reset stay outside as plain module ports.
//
//   req       [7:0]  one bit per requester, set while it wants the resource
//   done             one-cycle release pulse from the current owner
//   gnt       [7:0]  one-hot grant, all zero when nothing is granted
//   gnt_idx   [2:0]  binary index of the current owner
//   gnt_valid        high while a grant is held
//   timeout          one-cycle pulse when a grant is revoked for holding too long
//
// master : requester side (drives req/done)
// slave  : arbiter side   (drives the grant outputs)
// ---------------------------------------------------------------------------
interface rr_arbiter8_if;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8
// Eight-way round-robin arbiter with an optional hold-time limit.
// One requester owns the resource at a time. After every release the search
// pointer moves to the requester just past the previous owner, and at least
// one idle cycle separates consecutive grants.
//
// Parameters
//   MAX_HOLD  maximum consecutive cycles a grant may be held (0 = unlimited)
//
// Ports
//   clk   single clock, rising edge
//   rst   synchronous, active-high reset
//   bus   rr_arbiter8_if.slave : req/done in, gnt/gnt_idx/gnt_valid/timeout out
//
// State | meaning
// ------+------------------------------------------------------------
// IDLE  | no grant held; arbitrates among req when any bit is set
// GRANT | one requester owns the resource; waits for done, req drop
//       | or hold-time expiry
// ---------------------------------------------------------------------------
module rr_arbiter8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter8_if.slave  bus
);

    // A zero-width counter is not legal, so keep at least one bit when the
    // hold limit is disabled.
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_SAT = {HW{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          r_state;
    logic [2:0]      r_ptr;
    logic [2:0]      r_gnt_idx;
    logic [7:0]      r_gnt;
    logic            r_gnt_valid;
    logic            r_timeout;
    logic [HW-1:0]   r_hold_cnt;

    state_t          w_state_nxt;
    logic [2:0]      w_ptr_nxt;
    logic [2:0]      w_idx_nxt;
    logic [7:0]      w_gnt_nxt;
    logic            w_valid_nxt;
    logic            w_timeout_nxt;
    logic [HW-1:0]   w_hold_nxt;

    logic [2:0]      w_sel;
    logic [HW-1:0]   w_hold_inc;
    logic            w_expire;
    logic            w_owner_req;
    logic            w_release;

    // Round-robin pick: walk from ptr+7 down to ptr so the last hit, which
    // is the one closest to ptr in search order, wins.
    always_comb begin
        w_sel = r_ptr;
        for (int i = 7; i >= 0; i--) begin
            if (bus.req[r_ptr + 3'(i)]) begin
                w_sel = r_ptr + 3'(i);
            end
        end
    end

    // hold_cnt counts completed GRANT cycles; the incremented value reaching
    // MAX_HOLD means this is the last cycle the grant may be held.
    always_comb begin
        w_hold_inc = (r_hold_cnt == HOLD_SAT) ? r_hold_cnt : r_hold_cnt + 1'b1;
        w_expire   = (MAX_HOLD != 0) && (w_hold_inc == HOLD_LIM);
    end

    assign w_owner_req = bus.req[r_gnt_idx];
    assign w_release   = bus.done || !w_owner_req || w_expire;

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_idx_nxt     = r_gnt_idx;
        w_hold_nxt    = r_hold_cnt;
        w_timeout_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                // done is meaningless without an owner and is ignored here.
                if (bus.req != 8'h00) begin
                    w_state_nxt = GRANT;
                    w_idx_nxt   = w_sel;
                    w_hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_state_nxt   = IDLE;
                    w_ptr_nxt     = r_gnt_idx + 3'd1;
                    w_hold_nxt    = '0;
                    // An owner-initiated release in the expiry cycle is an
                    // ordinary release, not a timeout.
                    w_timeout_nxt = w_expire && !bus.done && w_owner_req;
                end else begin
                    w_hold_nxt = w_hold_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_valid_nxt = (w_state_nxt == GRANT);
        w_gnt_nxt   = w_valid_nxt ? (8'b1 << w_idx_nxt) : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= 3'd0;
            r_gnt_idx   <= 3'd0;
            r_gnt       <= 8'h00;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gnt_idx   <= w_idx_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_valid <= w_valid_nxt;
            r_timeout   <= w_timeout_nxt;
            r_hold_cnt  <= w_hold_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_idx   = r_gnt_idx;
    assign bus.gnt_valid = r_gnt_valid;
    assign bus.timeout   = r_timeout;

endmodule
